acc_req_arbiter: RTL and testbench

//  Shares one accelerator request/response channel (downstream interconnect slave port) among NumReq

---
 rtl/acc_req_arbiter_pkg.sv | 11 +
 rtl/acc_req_arbiter_rr_pick.sv | 74 +++++++
 rtl/acc_req_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_acc_req_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_req_arbiter_pkg.sv
// rtl/acc_req_arbiter_pkg.sv - shared widths and helpers for the accelerator request arbiter
package acc_req_arbiter_pkg;

   localparam int unsigned NumArgs = 3;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/acc_req_arbiter_rr_pick.sv
// rtl/acc_req_arbiter_rr_pick.sv - round-robin pick from an eligibility mask, with grant lock
// The lock pins the current grant while the downstream side stalls, so the payload stays stable.
module acc_req_arbiter_rr_pick
   import acc_req_arbiter_pkg::*;
#(
   parameter int unsigned  NumReq   = 4,
   localparam int unsigned IdxWidth = idx_width(NumReq)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumReq-1:0]   elig_i,
   input  logic                ready_i,
   output logic                gnt_valid_o,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic [NumReq-1:0]   gnt_oh_o
);

   logic [IdxWidth-1:0] ptr_q, ptr_d;
   logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
   logic                lock_q, lock_d;
   logic [IdxWidth-1:0] pick_idx;
   logic                pick_found;
   int                  j;

   // Walk downwards so the candidate closest to the pointer is the last one written.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         j = (int'(ptr_q) + k) % int'(NumReq);
         if (elig_i[IdxWidth'(j)]) begin
            pick_found = 1'b1;
            pick_idx   = IdxWidth'(j);
         end
      end
   end

   assign gnt_valid_o = lock_q || pick_found;
   assign gnt_idx_o   = lock_q ? lock_idx_q : pick_idx;

   always_comb begin
      gnt_oh_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         gnt_oh_o[i] = gnt_valid_o && (gnt_idx_o == IdxWidth'(i));
      end
   end

   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (gnt_valid_o && !ready_i) begin
         lock_d     = 1'b1;
         lock_idx_d = gnt_idx_o;
      end else if (gnt_valid_o) begin
         lock_d = 1'b0;
         ptr_d  = (gnt_idx_o == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx_o + IdxWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: rtl/acc_req_arbiter.sv
// rtl/acc_req_arbiter.sv - shares one accelerator channel among NumReq requesters, tags ids, demuxes responses
// Define ACC_ARB_REQ_CUT_EN to place a full-throughput spill register on the downstream request path.
module acc_req_arbiter
   import acc_req_arbiter_pkg::*;
#(
   parameter int unsigned  NumReq         = 4,
   parameter int unsigned  DataWidth      = 32,
   parameter int unsigned  AddrWidth      = 3,
   parameter int unsigned  IdWidth        = 1,
   parameter int unsigned  MaxOutstanding = 4,
   localparam int unsigned IdxWidth       = idx_width(NumReq),
   localparam int unsigned ReqWidth       = AddrWidth + (NumArgs + 1) * DataWidth + IdWidth,
   localparam int unsigned RspWidth       = DataWidth + 1 + IdWidth
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq*ReqWidth-1:0]    slv_req_i,
   input  logic [NumReq-1:0]             slv_req_valid_i,
   output logic [NumReq-1:0]             slv_req_ready_o,
   output logic [NumReq*RspWidth-1:0]    slv_rsp_o,
   output logic [NumReq-1:0]             slv_rsp_valid_o,
   input  logic [NumReq-1:0]             slv_rsp_ready_i,
   output logic [ReqWidth+IdxWidth-1:0]  mst_req_o,
   output logic                          mst_req_valid_o,
   input  logic                          mst_req_ready_i,
   input  logic [RspWidth+IdxWidth-1:0]  mst_rsp_i,
   input  logic                          mst_rsp_valid_i,
   output logic                          mst_rsp_ready_o
);

   localparam int unsigned MstIdWidth = IdWidth + IdxWidth;
   localparam int unsigned CntWidth   = idx_width(MaxOutstanding + 1);

   typedef struct packed {
      logic [AddrWidth-1:0]              addr;
      logic [DataWidth-1:0]              instr_data;
      logic [NumArgs-1:0][DataWidth-1:0] data_arg;
      logic [IdWidth-1:0]                id;
   } req_t;

   typedef struct packed {
      logic [AddrWidth-1:0]              addr;
      logic [DataWidth-1:0]              instr_data;
      logic [NumArgs-1:0][DataWidth-1:0] data_arg;
      logic [MstIdWidth-1:0]             id;
   } mst_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic                 error;
      logic [IdWidth-1:0]   id;
   } rsp_t;

   typedef struct packed {
      logic [DataWidth-1:0]  data;
      logic                  error;
      logic [MstIdWidth-1:0] id;
   } mst_rsp_t;

   req_t     [NumReq-1:0] slv_req;
   mst_rsp_t              mst_rsp;
   rsp_t                  rsp_out;
   req_t                  gnt_req;
   mst_req_t              arb_req;

   logic [CntWidth-1:0] cnt_q [NumReq];
   logic [CntWidth-1:0] cnt_d [NumReq];
   logic [NumReq-1:0]   elig, gnt_oh, rsp_oh;
   logic [IdxWidth-1:0] gnt_idx, rsp_sel;
   logic                gnt_valid, arb_valid, arb_ready, req_hs;
   logic                rsp_known, rsp_cnt_nz, rsp_sel_ready, rsp_ok, rsp_deliver, rsp_hs;

   assign slv_req = slv_req_i;
   assign mst_rsp = mst_rsp_i;

   // A requester at its in-flight limit is masked; a retire in the same cycle does not unmask it.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NumReq; i++) begin
         elig[i] = slv_req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
      end
   end

   acc_req_arbiter_rr_pick #(
      .NumReq (NumReq)
   ) i_rr_pick (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .elig_i      (elig),
      .ready_i     (arb_ready),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .gnt_oh_o    (gnt_oh)
   );

   always_comb begin
      gnt_req = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (gnt_oh[i]) gnt_req = slv_req[i];
      end
   end

   always_comb begin
      arb_req            = '0;
      arb_req.addr       = gnt_req.addr;
      arb_req.instr_data = gnt_req.instr_data;
      arb_req.data_arg   = gnt_req.data_arg;
      arb_req.id         = {gnt_idx, gnt_req.id};
   end

   assign arb_valid       = rst_ni && gnt_valid;
   assign req_hs          = arb_valid && arb_ready;
   assign slv_req_ready_o = (rst_ni && arb_ready) ? gnt_oh : '0;

`ifdef ACC_ARB_REQ_CUT_EN
   mst_req_t a_data_q, b_data_q;
   logic     a_full_q, b_full_q;
   logic     a_fill, a_drain, b_fill, b_drain;

   // Slot a takes new requests; slot b catches a's entry only when downstream stalls.
   assign arb_ready = !a_full_q || !b_full_q;
   assign a_fill    = arb_valid && arb_ready;
   assign a_drain   = a_full_q && !b_full_q;
   assign b_fill    = a_drain && !mst_req_ready_i;
   assign b_drain   = b_full_q && mst_req_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_data_q <= '0;
         b_data_q <= '0;
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
      end else begin
         if (a_fill) a_data_q <= arb_req;
         if (b_fill) b_data_q <= a_data_q;
         a_full_q <= a_fill || (a_full_q && !a_drain);
         b_full_q <= b_fill || (b_full_q && !b_drain);
      end
   end

   assign mst_req_valid_o = rst_ni && (a_full_q || b_full_q);
   assign mst_req_o       = mst_req_valid_o ? (b_full_q ? b_data_q : a_data_q) : '0;
`else
   assign arb_ready       = mst_req_ready_i;
   assign mst_req_valid_o = arb_valid;
   assign mst_req_o       = arb_valid ? arb_req : '0;
`endif

   assign rsp_sel = mst_rsp.id[MstIdWidth-1:IdWidth];

   always_comb begin
      rsp_known     = 1'b0;
      rsp_cnt_nz    = 1'b0;
      rsp_sel_ready = 1'b0;
      rsp_oh        = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (rsp_sel == IdxWidth'(i)) begin
            rsp_known     = 1'b1;
            rsp_oh[i]     = 1'b1;
            rsp_cnt_nz    = (cnt_q[i] != '0);
            rsp_sel_ready = slv_rsp_ready_i[i];
         end
      end
   end

   // Responses for unknown or idle requesters are swallowed rather than allowed to stall the channel.
   assign rsp_ok          = rsp_known && rsp_cnt_nz;
   assign mst_rsp_ready_o = rst_ni && (!rsp_ok || rsp_sel_ready);
   assign rsp_deliver     = rst_ni && mst_rsp_valid_i && rsp_ok;
   assign rsp_hs          = rsp_deliver && rsp_sel_ready;
   assign slv_rsp_valid_o = rsp_deliver ? rsp_oh : '0;

   always_comb begin
      rsp_out       = '0;
      rsp_out.data  = mst_rsp.data;
      rsp_out.error = mst_rsp.error;
      rsp_out.id    = mst_rsp.id[IdWidth-1:0];
   end

   always_comb begin
      slv_rsp_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (slv_rsp_valid_o[i]) slv_rsp_o[i*RspWidth +: RspWidth] = rsp_out;
      end
   end

   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_hs && gnt_oh[i] && !(rsp_hs && rsp_oh[i])) begin
            cnt_d[i] = cnt_q[i] + CntWidth'(1);
         end else if (rsp_hs && rsp_oh[i] && !(req_hs && gnt_oh[i])) begin
            cnt_d[i] = cnt_q[i] - CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   rsp_id_known_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      mst_rsp_valid_i |-> rsp_ok);

endmodule

// File: tb/tb_acc_req_arbiter.sv
// tb/tb_acc_req_arbiter.sv - directed self-checking bench for acc_req_arbiter
module tb_acc_req_arbiter;

   localparam int NumReq = 4;
   localparam int DataW  = 32;
   localparam int AddrW  = 3;
   localparam int IdW    = 1;
   localparam int IdxW   = 2;
   localparam int ReqW   = AddrW + 4 * DataW + IdW;
   localparam int RspW   = DataW + 1 + IdW;
   localparam int MReqW  = ReqW + IdxW;
   localparam int MRspW  = RspW + IdxW;

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic [NumReq*ReqW-1:0]   slv_req;
   logic [NumReq-1:0]        slv_req_valid;
   logic [NumReq-1:0]        slv_req_ready;
   logic [NumReq*RspW-1:0]   slv_rsp;
   logic [NumReq-1:0]        slv_rsp_valid;
   logic [NumReq-1:0]        slv_rsp_ready;
   logic [MReqW-1:0]         mst_req;
   logic                     mst_req_valid;
   logic                     mst_req_ready;
   logic [MRspW-1:0]         mst_rsp;
   logic                     mst_rsp_valid;
   logic                     mst_rsp_ready;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   acc_req_arbiter dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .slv_req_i       (slv_req),
      .slv_req_valid_i (slv_req_valid),
      .slv_req_ready_o (slv_req_ready),
      .slv_rsp_o       (slv_rsp),
      .slv_rsp_valid_o (slv_rsp_valid),
      .slv_rsp_ready_i (slv_rsp_ready),
      .mst_req_o       (mst_req),
      .mst_req_valid_o (mst_req_valid),
      .mst_req_ready_i (mst_req_ready),
      .mst_rsp_i       (mst_rsp),
      .mst_rsp_valid_i (mst_rsp_valid),
      .mst_rsp_ready_o (mst_rsp_ready)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [ReqW-1:0] mk_req(input int i);
      return {3'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h3000 + 32'(i),
              32'h4000 + 32'(i), 1'(i)};
   endfunction

   function automatic logic [MReqW-1:0] mk_mst(input int i);
      logic [ReqW-1:0] r;
      r = mk_req(i);
      return {r[ReqW-1:1], 2'(i), r[0]};
   endfunction

   task automatic idle_inputs();
      slv_req_valid = '0;
      slv_rsp_ready = '1;
      mst_req_ready = 1'b1;
      mst_rsp       = '0;
      mst_rsp_valid = 1'b0;
   endtask

   // Leaves the bench at a falling edge with reset released.
   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NumReq; i++) slv_req[i*ReqW +: ReqW] = mk_req(i);
      idle_inputs();
      slv_req_valid = '1;
      mst_rsp_valid = 1'b1;
      @(negedge clk_i);
      #2;
      chk("rst_mst_valid", mst_req_valid, 0);
      chk("rst_req_ready", slv_req_ready, 0);
      chk("rst_mst_req", mst_req, 0);
      chk("rst_rsp_ready", mst_rsp_ready, 0);
      chk("rst_rsp_valid", slv_rsp_valid, 0);
      chk("rst_slv_rsp", slv_rsp, 0);

      // Continuous requests from all four: strict rotation.
      do_reset();
      slv_req_valid = 4'hf;
      for (int k = 0; k < 8; k++) begin
         #2;
         chk("t1_valid", mst_req_valid, 1);
         chk("t1_mst_req", mst_req, mk_mst(k % 4));
         chk("t1_ready", slv_req_ready, 4'b0001 << (k % 4));
         @(negedge clk_i);
      end

      // Backpressure on grant 0 with requester 2 waiting.
      do_reset();
      slv_req_valid = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         mst_req_ready = (k == 3);
         #2;
         chk("t2_held", mst_req, mk_mst(0));
         chk("t2_ready", slv_req_ready, (k == 3) ? 4'b0001 : 4'b0000);
         @(negedge clk_i);
      end
      #2;
      chk("t2_next", mst_req, mk_mst(2));
      chk("t2_next_ready", slv_req_ready, 4'b0100);
      @(negedge clk_i);

      // Outstanding limit on requester 1, released by one response.
      do_reset();
      slv_req_valid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("t3_issue", slv_req_ready, 4'b0010);
         @(negedge clk_i);
      end
      mst_rsp       = {32'hCAFE0001, 1'b0, 2'd1, 1'b1};
      mst_rsp_valid = 1'b1;
      #2;
      chk("t3_throttled", slv_req_ready, 0);
      chk("t3_no_valid", mst_req_valid, 0);
      chk("t3_rsp_valid", slv_rsp_valid, 4'b0010);
      chk("t3_rsp_data", slv_rsp[RspW +: RspW], {32'hCAFE0001, 1'b0, 1'b1});
      chk("t3_rsp_ready", mst_rsp_ready, 1);
      @(negedge clk_i);
      mst_rsp_valid = 1'b0;
      #2;
      chk("t3_reopen", slv_req_ready, 4'b0010);
      @(negedge clk_i);

      // Response to requester 3 under upstream backpressure.
      do_reset();
      slv_req_valid = 4'b1000;
      #2;
      chk("t4_issue", slv_req_ready, 4'b1000);
      @(negedge clk_i);
      slv_req_valid = '0;
      mst_rsp       = {32'hBEEF0003, 1'b1, 2'd3, 1'b1};
      mst_rsp_valid = 1'b1;
      slv_rsp_ready = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) slv_rsp_ready = 4'hf;
         #2;
         chk("t4_rsp_valid", slv_rsp_valid, 4'b1000);
         chk("t4_rsp_port3", slv_rsp[3*RspW +: RspW], {32'hBEEF0003, 1'b1, 1'b1});
         chk("t4_rsp_port0", slv_rsp[0 +: RspW], 0);
         chk("t4_rsp_ready", mst_rsp_ready, (k == 2));
         @(negedge clk_i);
      end
      mst_rsp_valid = 1'b0;

      // Same-cycle issue and retire on requester 0 at two outstanding.
      do_reset();
      slv_req_valid = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         mst_rsp       = '0;
         mst_rsp_valid = (k == 2);
         #2;
         chk("t5_ready", slv_req_ready, (k < 5) ? 4'b0001 : 4'b0000);
         if (k == 2) chk("t5_rsp_ready", mst_rsp_ready, 1);
         @(negedge clk_i);
      end
      mst_rsp_valid = 1'b0;

      // Reset while locked with outstanding counts {1,2,0,3}.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         automatic int r = (k == 0) ? 0 : (k < 3) ? 1 : 3;
         slv_req_valid = 4'b0001 << r;
         #2;
         chk("t6_fill", slv_req_ready, 4'b0001 << r);
         @(negedge clk_i);
      end
      slv_req_valid = 4'b0010;
      mst_req_ready = 1'b0;
      #2;
      chk("t6_stall_valid", mst_req_valid, 1);
      @(negedge clk_i);
      slv_req_valid = 4'hf;
      #2;
      chk("t6_lock", mst_req, mk_mst(1));
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", mst_req_valid, 0);
      chk("t6_rst_ready", slv_req_ready, 0);
      chk("t6_rst_req", mst_req, 0);
      repeat (2) @(negedge clk_i);
      rst_ni        = 1'b1;
      mst_req_ready = 1'b1;
      #2;
      chk("t6_ptr0", mst_req, mk_mst(0));
      @(negedge clk_i);
      slv_req_valid = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("t6_cnt3", slv_req_ready, (k < 4) ? 4'b1000 : 4'b0000);
         @(negedge clk_i);
      end
      slv_req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
